// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: tagged BHT+BTB for the pipelined MIPS core.
// Combinational lookup in IF, update from the branch-resolve stage,
// saturating mispredict counter, table re-initialised by a walk FSM.
// Optional feature macro: BP_GSHARE_EN (global-history XOR indexing).
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_INIT   | walking ptr over the table, clearing valid, cnt<=weak NT
// ST_RUN    | table valid, lookups live, updates accepted
module branch_predictor_bht #(
    parameter int ENTRIES = 64,
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    output logic               ready_o,
    input  logic [31:0]        pc_i,
    output logic               pred_taken_o,
    output logic [31:0]        pred_target_o,
    output logic [INDEX_W-1:0] pred_idx_o,
    input  logic               upd_valid_i,
    input  logic [INDEX_W-1:0] upd_idx_i,
    input  logic [31:0]        upd_pc_i,
    input  logic               upd_taken_i,
    input  logic               upd_pred_i,
    input  logic [31:0]        upd_target_i,
    output logic [15:0]        miss_cnt_o
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_WNT = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_WT  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [INDEX_W-1:0] PTR_LAST = INDEX_W'(ENTRIES - 1);

    logic [0:0]         state_q, state_d;
    logic [INDEX_W-1:0] ptr_q, ptr_d;
    logic [15:0]        miss_q, miss_d;

    logic               valid_q  [ENTRIES];
    logic               valid_d  [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [CNT_W-1:0]   cnt_q    [ENTRIES];
    logic [CNT_W-1:0]   cnt_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];

    logic [INDEX_W-1:0] lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic [TAG_W-1:0]   upd_tag;
    logic               run;
    logic               upd_hit;

`ifdef BP_GSHARE_EN
    logic [INDEX_W-1:0] ghr_q, ghr_d;
`endif

    // Bits of the PCs that neither index nor tag the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_i[31:TAG_W+INDEX_W+2], pc_i[1:0],
                              upd_pc_i[31:TAG_W+INDEX_W+2], upd_pc_i[INDEX_W+1:0]};

    assign run     = (state_q == ST_RUN);
    assign ready_o = run;
    assign lk_tag  = pc_i[TAG_W+INDEX_W+1:INDEX_W+2];
    assign upd_tag = upd_pc_i[TAG_W+INDEX_W+1:INDEX_W+2];
    assign miss_cnt_o = miss_q;

    // Lookup: index hash, tag compare and counter MSB; target masked when not taken.
    always_comb begin
`ifdef BP_GSHARE_EN
        lk_idx = pc_i[INDEX_W+1:2] ^ ghr_q;
`else
        lk_idx = pc_i[INDEX_W+1:2];
`endif
        pred_idx_o    = lk_idx;
        pred_taken_o  = run && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag)
                        && cnt_q[lk_idx][CNT_W-1];
        pred_target_o = pred_taken_o ? target_q[lk_idx] : 32'h0;
    end

    // Next-state: init walk, flush, table update, mispredict counter.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        miss_d   = miss_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        upd_hit  = valid_q[upd_idx_i] && (tag_q[upd_idx_i] == upd_tag);
`ifdef BP_GSHARE_EN
        ghr_d    = ghr_q;
`endif
        case (state_q)
            ST_INIT: begin
                valid_d[ptr_q] = 1'b0;
                cnt_d[ptr_q]   = CNT_WNT;
                ptr_d          = ptr_q + 1'b1;
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                // A flush wins over a same-cycle update; the update is lost.
                if (flush_i) begin
                    state_d = ST_INIT;
                    ptr_d   = '0;
`ifdef BP_GSHARE_EN
                    ghr_d   = '0;
`endif
                end else if (upd_valid_i) begin
`ifdef BP_GSHARE_EN
                    ghr_d = {ghr_q[INDEX_W-2:0], upd_taken_i};
`endif
                    if (upd_hit) begin
                        if (upd_taken_i) begin
                            if (cnt_q[upd_idx_i] != CNT_MAX) begin
                                cnt_d[upd_idx_i] = cnt_q[upd_idx_i] + 1'b1;
                            end
                            target_d[upd_idx_i] = upd_target_i;
                        end else if (cnt_q[upd_idx_i] != '0) begin
                            cnt_d[upd_idx_i] = cnt_q[upd_idx_i] - 1'b1;
                        end
                    end else if (upd_taken_i) begin
                        valid_d[upd_idx_i]  = 1'b1;
                        tag_d[upd_idx_i]    = upd_tag;
                        target_d[upd_idx_i] = upd_target_i;
                        cnt_d[upd_idx_i]    = CNT_WT;
                    end
                end
                if (upd_valid_i && (upd_taken_i != upd_pred_i) && (miss_q != 16'hFFFF)) begin
                    miss_d = miss_q + 16'd1;
                end
            end
        endcase
    end

    // Control flops with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            miss_q  <= '0;
`ifdef BP_GSHARE_EN
            ghr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            miss_q  <= miss_d;
`ifdef BP_GSHARE_EN
            ghr_q   <= ghr_d;
`endif
        end
    end

    // Table storage; contents are not reset, the init walk invalidates them.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Testbench for branch_predictor_bht: directed scenarios plus random
// traffic, compared against a behavioural table model.
module tb_branch_predictor_bht;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        ready_o;
    logic [31:0] pc_i;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic [5:0]  pred_idx_o;
    logic        upd_valid_i;
    logic [5:0]  upd_idx_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic        upd_pred_i;
    logic [31:0] upd_target_i;
    logic [15:0] miss_cnt_o;

    branch_predictor_bht dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .ready_o(ready_o),
        .pc_i(pc_i), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
        .pred_idx_o(pred_idx_o), .upd_valid_i(upd_valid_i), .upd_idx_i(upd_idx_i),
        .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i), .upd_pred_i(upd_pred_i),
        .upd_target_i(upd_target_i), .miss_cnt_o(miss_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          m_valid [64];
    int unsigned m_tag   [64];
    int          m_cnt   [64];
    int unsigned m_tgt   [64];
    int          init_left = 64;
    int          m_miss = 0;
    int unsigned m_ghr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned midx(input logic [31:0] pc);
        int unsigned i;
        i = (pc >> 2) & 63;
`ifdef BP_GSHARE_EN
        i = i ^ m_ghr;
`endif
        return i;
    endfunction

    // Applies one clock edge worth of the behavioural rules to the model.
    task automatic model_step();
        int unsigned e;
        int unsigned t;
        if (!rst) begin
            init_left = 64;
            m_miss    = 0;
            m_ghr     = 0;
        end else if (init_left > 0) begin
            m_valid[64 - init_left] = 1'b0;
            m_cnt[64 - init_left]   = 1;
            init_left--;
        end else begin
            if (upd_valid_i && (upd_taken_i != upd_pred_i) && m_miss < 65535) m_miss++;
            if (flush_i) begin
                init_left = 64;
                m_ghr     = 0;
            end else if (upd_valid_i) begin
                e = upd_idx_i;
                t = (upd_pc_i >> 8) & 255;
                if (m_valid[e] && m_tag[e] == t) begin
                    if (upd_taken_i) begin
                        if (m_cnt[e] < 3) m_cnt[e]++;
                        m_tgt[e] = upd_target_i;
                    end else if (m_cnt[e] > 0) begin
                        m_cnt[e]--;
                    end
                end else if (upd_taken_i) begin
                    m_valid[e] = 1'b1;
                    m_tag[e]   = t;
                    m_tgt[e]   = upd_target_i;
                    m_cnt[e]   = 2;
                end
                m_ghr = ((m_ghr << 1) | int'(upd_taken_i)) & 63;
            end
        end
    endtask

    task automatic tick(input bit full_chk);
        model_step();
        @(posedge clk);
        #1;
        if (full_chk) begin
            chk("ready", {31'b0, ready_o}, {31'b0, init_left == 0});
            chk("miss_cnt", {16'b0, miss_cnt_o}, m_miss);
        end
    endtask

    task automatic lookup(input logic [31:0] pc);
        int unsigned i;
        bit exp_t;
        pc_i = pc;
        #1;
        i = midx(pc);
        exp_t = (init_left == 0) && m_valid[i] && (m_tag[i] == ((pc >> 8) & 255)) && (m_cnt[i] >= 2);
        chk("pred_taken", {31'b0, pred_taken_o}, {31'b0, exp_t});
        chk("pred_target", pred_target_o, exp_t ? m_tgt[i] : 32'h0);
        chk("pred_idx", {26'b0, pred_idx_o}, i);
    endtask

    task automatic set_upd(input bit v, input logic [31:0] pc, input bit tk,
                           input bit pr, input logic [31:0] tgt);
        upd_valid_i  = v;
        upd_pc_i     = pc;
        upd_idx_i    = 6'(midx(pc));
        upd_taken_i  = tk;
        upd_pred_i   = pr;
        upd_target_i = tgt;
    endtask

    task automatic upd_tick(input logic [31:0] pc, input bit tk, input bit pr, input logic [31:0] tgt);
        set_upd(1'b1, pc, tk, pr, tgt);
        tick(1'b1);
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] rpc;
        rst = 1'b0;
        flush_i = 1'b0;
        pc_i = 32'h00400010;
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Scenario 1: one reset cycle, then 64 cycles of INIT
        tick(1'b0);
        rst = 1'b1;
        chk("rst_ready", {31'b0, ready_o}, 32'h0);
        chk("rst_miss", {16'b0, miss_cnt_o}, 32'h0);
        for (int c = 0; c < 64; c++) begin
            set_upd(1'($urandom_range(0, 1)), 32'h00400010, 1'b1, 1'b0, 32'h00400040);
            lookup(32'h00400010);
            chk("init_taken", {31'b0, pred_taken_o}, 32'h0);
            tick(1'b1);
        end
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("init_done", {31'b0, ready_o}, 32'h1);
        chk("init_no_miss", {16'b0, miss_cnt_o}, 32'h0);

        // Scenario 2: allocate on a taken update
        upd_tick(32'h00400010, 1'b1, 1'b0, 32'h00400040);
        lookup(32'h00400010);
`ifdef BP_GSHARE_EN
        chk("gshare_idx", {26'b0, pred_idx_o}, 32'd5);
`else
        chk("s2_taken", {31'b0, pred_taken_o}, 32'h1);
        chk("s2_target", pred_target_o, 32'h00400040);
`endif

        // Scenario 3: saturate up, count down, saturate at 0
        for (int k = 0; k < 3; k++) upd_tick(32'h00400010, 1'b1, 1'b1, 32'h00400040);
        for (int k = 0; k < 2; k++) upd_tick(32'h00400010, 1'b0, 1'b1, 32'h00400040);
        lookup(32'h00400010);
`ifndef BP_GSHARE_EN
        chk("s3_nt", {31'b0, pred_taken_o}, 32'h0);
`endif
        upd_tick(32'h00400010, 1'b0, 1'b0, 32'h00400040);
        upd_tick(32'h00400010, 1'b1, 1'b0, 32'h00400080);
        lookup(32'h00400010);
`ifndef BP_GSHARE_EN
        chk("s3_floor", {31'b0, pred_taken_o}, 32'h0);
`endif

        // Scenario 4: tag conflict at index 4, then replacement
        upd_tick(32'h00400010, 1'b1, 1'b0, 32'h00400080);
        lookup(32'h00400010);
        lookup(32'h00400110);
`ifndef BP_GSHARE_EN
        chk("s4_other_tag", {31'b0, pred_taken_o}, 32'h0);
`endif
        upd_tick(32'h00400110, 1'b1, 1'b0, 32'h00400500);
        lookup(32'h00400010);
`ifndef BP_GSHARE_EN
        chk("s4_evicted", {31'b0, pred_taken_o}, 32'h0);
`endif
        lookup(32'h00400110);

        // Scenario 5: flush with same-cycle update
        flush_i = 1'b1;
        set_upd(1'b1, 32'h00400200, 1'b1, 1'b1, 32'h00400900);
        tick(1'b1);
        flush_i = 1'b0;
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 64; c++) begin
            chk("flush_ready", {31'b0, ready_o}, 32'h0);
            lookup(32'h00400200);
            tick(1'b1);
        end
        chk("flush_done", {31'b0, ready_o}, 32'h1);
        lookup(32'h00400010);
        chk("flush_a", {31'b0, pred_taken_o}, 32'h0);
        lookup(32'h00400110);
        chk("flush_b", {31'b0, pred_taken_o}, 32'h0);
        lookup(32'h00400200);
        chk("flush_c", {31'b0, pred_taken_o}, 32'h0);

        // Random traffic with aliasing PCs, occasional flush and reset
        for (int c = 0; c < 2500; c++) begin
            rpc = 32'h00400000 | (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 8);
            set_upd(1'($urandom_range(0, 1)), rpc, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
            flush_i = ($urandom_range(0, 299) == 0);
            rst = !(c == 1200 || c == 1230);
            rpc = 32'h00400000 | (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 8);
            lookup(rpc);
            tick(1'b1);
        end
        rst = 1'b1;
        flush_i = 1'b0;
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 70 && init_left > 0; c++) tick(1'b1);

        // Scenario 6: mispredict counter saturation
        set_upd(1'b1, 32'h00400300, 1'b1, 1'b0, 32'h00401000);
        for (int c = 0; c < 70000; c++) begin
            upd_pc_i  = 32'h00400300 | (32'(c & 7) << 2);
            upd_idx_i = 6'(midx(upd_pc_i));
            tick(c > 69990);
        end
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick(1'b1);
        chk("miss_sat", {16'b0, miss_cnt_o}, 32'h0000FFFF);
        lookup(32'h00400300);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
